// File: rtl/trace_reader.sv
// Traceback path decoder: reads (x,y) entries from memory in address order and
// turns each step into an alignment op (TOP / LEFT / MATCH / MISMATCH) on a valid/ready stream.
module trace_reader #(
  parameter int LENGTH      = 10,
  parameter int CWIDTH      = 2,
  parameter int CORD_LENGTH = 8,
  parameter int MEM_SIZE    = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [MEM_SIZE-1:0]        path_len,
  input  logic [LENGTH*CWIDTH-1:0]   s1,
  input  logic [LENGTH*CWIDTH-1:0]   s2,
  output logic [MEM_SIZE-1:0]        raddr,
  input  logic [2*CORD_LENGTH-1:0]   rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_op,
  output logic [CWIDTH-1:0]          out_c1,
  output logic [CWIDTH-1:0]          out_c2,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  // Stream handshake: an op transfers on a rising edge where out_valid and
  // out_ready are both high; while out_valid is high without out_ready, the
  // op and its characters stay unchanged.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_TOP      = 2'b00;
  localparam logic [1:0] OP_LEFT     = 2'b01;
  localparam logic [1:0] OP_MATCH    = 2'b10;
  localparam logic [1:0] OP_MISMATCH = 2'b11;

  localparam logic [CORD_LENGTH-1:0] LEN_C  = CORD_LENGTH'(LENGTH);
  localparam logic [CORD_LENGTH-1:0] LAST_C = CORD_LENGTH'(LENGTH - 1);
  localparam logic [CORD_LENGTH-1:0] ZERO_C = '0;
  localparam logic [CORD_LENGTH-1:0] ONE_C  = CORD_LENGTH'(1);
  localparam logic [MEM_SIZE-1:0]    MAX_PATH = MEM_SIZE'(2 * LENGTH - 1);
  localparam logic [MEM_SIZE-1:0]    ONE_A    = MEM_SIZE'(1);

  state_t                  state_q, state_d;
  logic [MEM_SIZE-1:0]     raddr_q, raddr_d;
  logic [CORD_LENGTH-1:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [CORD_LENGTH-1:0]  nxt_x_q, nxt_x_d, nxt_y_q, nxt_y_d;
  logic                    first_q, first_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic [CORD_LENGTH-1:0]  rd_x, rd_y, rd_dx, rd_dy, step_dx, step_dy;
  logic                    rd_in_range, rd_step_ok;
  logic [CWIDTH-1:0]       c1, c2;

  function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] s,
                                                input logic [CORD_LENGTH-1:0]   idx);
    logic [CWIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < LENGTH; i++) begin
      if (idx == CORD_LENGTH'(i)) c = s[i*CWIDTH +: CWIDTH];
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      nxt_x_q <= '0;
      nxt_y_q <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      nxt_x_q <= nxt_x_d;
      nxt_y_q <= nxt_y_d;
      first_q <= first_d;
      last_q  <= last_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    nxt_x_d = nxt_x_q;
    nxt_y_d = nxt_y_q;
    first_d = first_q;
    last_d  = last_q;
    error_d = error_q;
    done_d  = (state_q == S_DONE);

    rd_x        = rdata[CORD_LENGTH-1:0];
    rd_y        = rdata[2*CORD_LENGTH-1:CORD_LENGTH];
    rd_dx       = cur_x_q - rd_x;
    rd_dy       = cur_y_q - rd_y;
    rd_in_range = (rd_x < LEN_C) && (rd_y < LEN_C);
    rd_step_ok  = ((rd_dx == ONE_C)  && (rd_dy == ONE_C)) ||
                  ((rd_dx == ZERO_C) && (rd_dy == ONE_C)) ||
                  ((rd_dx == ONE_C)  && (rd_dy == ZERO_C));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          raddr_d = '0;
          first_d = 1'b1;
          last_d  = 1'b0;
          // Bad lengths are rejected before any memory access.
          if ((path_len == '0) || (path_len > MAX_PATH)) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (first_q) begin
          first_d = 1'b0;
          cur_x_d = rd_x;
          cur_y_d = rd_y;
          if ((rd_x != LAST_C) || (rd_y != LAST_C)) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (path_len == ONE_A) begin
            if ((rd_x != ZERO_C) || (rd_y != ZERO_C)) begin
              error_d = 1'b1;
              state_d = S_DONE;
            end else begin
              last_d  = 1'b1;
              state_d = S_EMIT;
            end
          end else begin
            raddr_d = ONE_A;
            state_d = S_FETCH;
          end
        end else if (raddr_q == path_len) begin
          // Past the end: current already holds the final (0,0) entry.
          last_d  = 1'b1;
          state_d = S_EMIT;
        end else begin
          nxt_x_d = rd_x;
          nxt_y_d = rd_y;
          if (!rd_in_range || !rd_step_ok) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if ((raddr_q == path_len - ONE_A) &&
                       ((rd_x != ZERO_C) || (rd_y != ZERO_C))) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            cur_x_d = nxt_x_q;
            cur_y_d = nxt_y_q;
            raddr_d = raddr_q + ONE_A;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    step_dx   = cur_x_q - nxt_x_q;
    step_dy   = cur_y_q - nxt_y_q;
    c1        = char_at(s1, cur_y_q);
    c2        = char_at(s2, cur_x_q);
    out_valid = (state_q == S_EMIT);
    out_op    = '0;
    out_c1    = '0;
    out_c2    = '0;
    if (out_valid) begin
      if (last_q || ((step_dx == ONE_C) && (step_dy == ONE_C))) begin
        out_op = (c1 == c2) ? OP_MATCH : OP_MISMATCH;
        out_c1 = c1;
        out_c2 = c2;
      end else if (step_dx == ZERO_C) begin
        out_op = OP_TOP;
        out_c1 = c1;
      end else begin
        out_op = OP_LEFT;
        out_c2 = c2;
      end
    end
  end

  assign raddr = raddr_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_trace_reader.sv
// Directed bench for trace_reader (LENGTH=4): op streams, stalls, bad paths,
// bad lengths and mid-run reset, checked against hand-computed expectations.
module tb_trace_reader;

  localparam int L  = 4;
  localparam int CW = 2;
  localparam int CL = 8;
  localparam int MS = 9;

  localparam logic [1:0] OP_TOP = 2'b00, OP_LEFT = 2'b01, OP_MATCH = 2'b10, OP_MISMATCH = 2'b11;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [MS-1:0]     path_len;
  logic [L*CW-1:0]   s1, s2;
  logic [MS-1:0]     raddr;
  logic [2*CL-1:0]   rdata;
  logic              out_valid, out_ready;
  logic [1:0]        out_op;
  logic [CW-1:0]     out_c1, out_c2;
  logic              busy, done, error;

  logic [2*CL-1:0]   mem [0:31];
  logic [5:0]        exp_q[$];
  int                n_chk;
  int                n_bad;

  trace_reader #(.LENGTH(L), .CWIDTH(CW), .CORD_LENGTH(CL), .MEM_SIZE(MS)) dut (
    .clk(clk), .reset(rst_n), .start(start), .path_len(path_len),
    .s1(s1), .s2(s2), .raddr(raddr), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_c1(out_c1), .out_c2(out_c2), .busy(busy), .done(done), .error(error)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rdata <= mem[raddr[4:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  task automatic set_entry(input int a, input int x, input int y);
    mem[a] = {8'(y), 8'(x)};
  endtask

  task automatic push_op(input logic [1:0] op, input logic [1:0] c1, input logic [1:0] c2);
    exp_q.push_back({op, c1, c2});
  endtask

  task automatic start_op(input int len);
    @(negedge clk);
    path_len = MS'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input int k, input int stall);
    int         cyc;
    logic [5:0] e;
    out_ready = (k == stall) ? 1'b0 : 1'b1;
    wait_valid(cyc);
    chk($sformatf("lat%0d", k), cyc, (k == 0) ? 5 : 3);
    chk($sformatf("valid%0d", k), out_valid, 1);
    e = (exp_q.size() > 0) ? exp_q[0] : 6'h3f;
    chk($sformatf("op%0d", k), out_op, e[5:4]);
    chk($sformatf("c1_%0d", k), out_c1, e[3:2]);
    chk($sformatf("c2_%0d", k), out_c2, e[1:0]);
    chk($sformatf("raddr%0d", k), raddr, k + 1);
    if (k == stall) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("stall_valid", out_valid, 1);
        chk("stall_op", out_op, e[5:4]);
        chk("stall_c1", out_c1, e[3:2]);
        chk("stall_c2", out_c2, e[1:0]);
        chk("stall_raddr", raddr, k + 1);
      end
      out_ready = 1'b1;
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic wait_done(output int cyc, output int vseen, output int rmoved);
    cyc = 1; vseen = 0; rmoved = 0;
    while (!done && cyc < 40) begin
      if (out_valid) vseen++;
      if (raddr != '0) rmoved++;
      @(negedge clk);
      cyc++;
    end
    if (raddr != '0) rmoved++;
    chk("done_seen", done, 1);
  endtask

  task automatic run_path(input int n, input int stall, input string name);
    int cyc, vs, rm;
    start_op(n);
    for (int k = 0; k < n; k++) do_op(k, stall);
    wait_done(cyc, vs, rm);
    chk({name, "_done_lat"}, cyc, 2);
    chk({name, "_err"}, error, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 0);
  endtask

  task automatic load_diag();
    clear_mem();
    s1 = 8'b11_10_01_00;
    s2 = 8'b11_10_01_00;
    set_entry(0, 3, 3); set_entry(1, 2, 2); set_entry(2, 1, 1); set_entry(3, 0, 0);
    exp_q.delete();
    push_op(OP_MATCH, 3, 3); push_op(OP_MATCH, 2, 2);
    push_op(OP_MATCH, 1, 1); push_op(OP_MATCH, 0, 0);
  endtask

  initial begin
    int cyc, vs, rm;
    n_chk = 0; n_bad = 0;
    start = 1'b0; out_ready = 1'b1; path_len = '0;
    s1 = '0; s2 = '0;
    clear_mem();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_op", {out_op, out_c1, out_c2}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // diagonal path: four matches
    load_diag();
    run_path(4, -1, "diag");

    // mixed path with a stall on the second op
    clear_mem();
    s1 = 8'b11_10_01_00;
    s2 = 8'b10_11_01_00;
    set_entry(0, 3, 3); set_entry(1, 3, 2); set_entry(2, 2, 1);
    set_entry(3, 1, 0); set_entry(4, 0, 0);
    exp_q.delete();
    push_op(OP_TOP, 3, 0);
    push_op(OP_MATCH, 2, 2);
    push_op(OP_MISMATCH, 1, 3);
    push_op(OP_LEFT, 0, 1);
    push_op(OP_MATCH, 0, 0);
    run_path(5, 1, "mixed");

    // illegal step (3,3)->(1,3)
    clear_mem();
    set_entry(0, 3, 3); set_entry(1, 1, 3);
    exp_q.delete();
    start_op(2);
    wait_done(cyc, vs, rm);
    chk("bad_step_lat", cyc, 6);
    chk("bad_step_noop", vs, 0);
    chk("bad_step_err", error, 1);
    @(negedge clk);
    chk("bad_step_done_pulse", done, 0);
    chk("bad_step_err_hold", error, 1);

    // zero length
    start_op(0);
    wait_done(cyc, vs, rm);
    chk("len0_lat", cyc, 2);
    chk("len0_err", error, 1);
    chk("len0_raddr", rm, 0);
    chk("len0_noop", vs, 0);

    // oversize length (max legal is 7)
    start_op(8);
    wait_done(cyc, vs, rm);
    chk("len8_lat", cyc, 2);
    chk("len8_err", error, 1);
    chk("len8_raddr", rm, 0);

    // reset during the second EMIT, then replay from entry 0
    load_diag();
    start_op(4);
    do_op(0, -1);
    wait_valid(cyc);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_op", {out_op, out_c1, out_c2}, 0);
    chk("arst_raddr", raddr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_error", error, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", busy, 0);
    load_diag();
    run_path(4, -1, "replay");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/trace_reader.md
TRACE_READER -- requirements
Module: trace_reader

Interface
REQ-001 The block SHALL have parameter LENGTH, default 10, meaning characters per string.
REQ-002 The block SHALL have parameter CWIDTH, default 2, meaning bits per character.
REQ-003 The block SHALL have parameter CORD_LENGTH, default 8, meaning bits per coordinate.
REQ-004 The block SHALL have parameter MEM_SIZE, default 9, meaning traceback memory address width.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit, a request to begin decoding.
REQ-008 The block SHALL have port path_len, input, MEM_SIZE bits, the number of traceback entries stored.
REQ-009 The block SHALL have ports s1 and s2, input, LENGTH*CWIDTH bits each, holding the source strings; character i is at [i*CWIDTH +: CWIDTH].
REQ-010 The block SHALL have port raddr, output, MEM_SIZE bits, the memory read address.
REQ-011 The block SHALL have port rdata, input, 2*CORD_LENGTH bits, where x = [CORD_LENGTH-1:0] and y = [2*CORD_LENGTH-1:CORD_LENGTH]; it SHALL be valid one cycle after raddr.
REQ-012 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_op (output, 2), out_c1 (output, CWIDTH) and out_c2 (output, CWIDTH), forming the alignment-op stream.
REQ-013 The block SHALL have ports busy, done and error, each output, 1 bit, carrying status.

Function
REQ-014 Entries at addresses 0..path_len-1 SHALL be a traceback path from (LENGTH-1,LENGTH-1) to (0,0); the block SHALL emit exactly path_len ops in address order.
REQ-015 out_op encoding SHALL be: 00 TOP (s1[y] vs gap), 01 LEFT (gap vs s2[x]), 10 MATCH, 11 MISMATCH.
REQ-016 For each entry i<path_len-1, the op SHALL be chosen from (dx,dy) = current minus next entry: (1,1) gives MATCH or MISMATCH by comparing s1[y] with s2[x]; (0,1) gives TOP; (1,0) gives LEFT; any other delta SHALL raise an error.
REQ-017 Each op SHALL use the current entry's coordinates: out_c1 = s1[y], out_c2 = s2[x]; on TOP out_c2 SHALL be 0, and on LEFT out_c1 SHALL be 0.
REQ-018 The final entry SHALL be (0,0) and SHALL emit MATCH or MISMATCH from s1[0] vs s2[0].
REQ-019 The FSM SHALL have states IDLE, FETCH, LOAD, EMIT and DONE.
REQ-020 In IDLE, start=1 SHALL move the FSM to FETCH with raddr=0; start SHALL be ignored in any other state.
REQ-021 FETCH SHALL present raddr and wait one cycle; LOAD SHALL capture rdata.
REQ-022 The first LOAD SHALL only fill the current entry and then return to FETCH for address 1; when path_len=1 it SHALL go directly to EMIT for the final op.
REQ-023 Subsequent LOADs SHALL fill the next entry and then go to EMIT.
REQ-024 In EMIT, out_valid SHALL be 1, and out_op, out_c1 and out_c2 SHALL be held stable until out_valid and out_ready are both high on the same edge.
REQ-025 On that handshake, the block SHALL set current to next, increment raddr and return to FETCH; after the last op it SHALL go to DONE.
REQ-026 Start-to-first-out_valid latency SHALL be 5 cycles; each subsequent op SHALL follow 3 cycles after the prior handshake, with out_ready held high.
REQ-027 DONE SHALL pulse done=1 for one cycle and then return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-028 Error conditions SHALL be: path_len=0; path_len>2*LENGTH-1; entry 0 not equal to (LENGTH-1,LENGTH-1); the last entry not (0,0); an illegal delta; or a coordinate ≥LENGTH.
REQ-029 On an error, the block SHALL emit no op for the offending step, go to DONE with error=1, and hold error until the next accepted start.
REQ-030 A path_len=0 or oversize path_len SHALL be detected in the start cycle, so that DONE follows immediately with no memory read.

Reset
REQ-031 While reset=0, the block SHALL be in IDLE with raddr=0, out_valid=0, out_op=0, out_c1=0, out_c2=0, busy=0, done=0 and error=0.
REQ-032 Reset asserted mid-operation SHALL abort immediately, and any pending op SHALL be discarded.
REQ-033 After reset is released, the block SHALL wait for a new start.

Verification
REQ-034 With LENGTH=4, s1=s2={0,1,2,3} and path (3,3),(2,2),(1,1),(0,0), the bench SHALL check four MATCH ops with c1/c2 = 3,2,1,0, then done and error=0.
REQ-035 With LENGTH=4 and path (3,3),(3,2),(2,1),(1,0),(0,0), the bench SHALL check the ops TOP, MATCH or MISMATCH per the characters, MATCH or MISMATCH, LEFT, then the final op.
REQ-036 The bench SHALL hold out_ready=0 for 5 cycles during EMIT and check that out_valid stays 1 with out_op and chars unchanged, and that raddr does not advance.
REQ-037 With path (3,3),(1,3), the bench SHALL check that no op is emitted, done pulses and error=1.
REQ-038 The bench SHALL check that path_len=0 gives done and error=1 two cycles after start, with raddr never leaving 0.
REQ-039 The bench SHALL assert reset during the second EMIT and check all outputs return to 0 asynchronously, and that a new start then replays the path from entry 0.
